// File: rtl/fosfor_present_pkg.sv
// Shared constants and types for the PRESENT-80 engine: S-box, pin-level
// address/command codes, status bit positions and the controller states.
package fosfor_present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    ADDR_IDLE = 2'b00,
    ADDR_CMD  = 2'b01,
    ADDR_DATA = 2'b10,
    ADDR_KEY  = 2'b11
  } addr_e;

  typedef enum logic [3:0] {
    CMD_NOP     = 4'd0,
    CMD_START   = 4'd1,
    CMD_RD_RST  = 4'd2,
    CMD_RD_NEXT = 4'd3,
    CMD_ABORT   = 4'd4,
    CMD_CLR_ERR = 4'd5
  } cmd_e;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERR     = 2;
  localparam int STAT_PTR_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN,
    ST_DONE
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    return SBOX[n];
  endfunction

endpackage

// File: rtl/fosfor_present_if.sv
// Host-side pin bundle of the engine: access select, write data and the
// registered read data.
interface fosfor_present_if #(
  parameter int DIN_W  = 4,
  parameter int DOUT_W = 8
);
  logic [1:0]        addr;
  logic [DIN_W-1:0]  din;
  logic [DOUT_W-1:0] dout;

  modport master (output addr, output din, input dout);
  modport slave  (input addr, input din, output dout);
endinterface

// File: rtl/fosfor_present_round.sv
// One combinational PRESENT-80 round: addRoundKey, sLayer, pLayer and the
// key-schedule step for round counter rc_i.
module fosfor_present_round
  import fosfor_present_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [KEY_W-1:0]   rkey_i,
  input  logic [4:0]         rc_i,
  output logic [BLOCK_W-1:0] state_o,
  output logic [KEY_W-1:0]   rkey_o
);

  logic [BLOCK_W-1:0] mixed;
  logic [BLOCK_W-1:0] subst;
  logic [KEY_W-1:0]   rot;

  always_comb begin
    mixed   = state_i ^ rkey_i[79:16];
    subst   = '0;
    state_o = '0;
    for (int n = 0; n < 16; n++) begin
      subst[4*n +: 4] = sbox(mixed[4*n +: 4]);
    end
    // Bit i moves to 16*i mod 63, written as (i%4)*16 + i/4.
    for (int i = 0; i < BLOCK_W; i++) begin
      state_o[(i % 4) * 16 + i / 4] = subst[i];
    end
  end

  always_comb begin
    // Rotate left by 61 is the same as rotate right by 19.
    rot          = {rkey_i[18:0], rkey_i[79:19]};
    rot[79:76]   = sbox(rot[79:76]);
    rot[19:15]   = rot[19:15] ^ rc_i;
    rkey_o       = rot;
  end

endmodule

// File: rtl/fosfor_present_engine.sv
// Iterative PRESENT-80 encryptor behind a narrow address-multiplexed pin
// interface: shift-in registers, command decode, round FSM and read mux.
module fosfor_present_engine
  import fosfor_present_pkg::*;
#(
  parameter int DIN_W  = 4,
  parameter int DOUT_W = 8,
  parameter int ROUNDS = 31
) (
  input  logic              Clk_ik,
  input  logic              Reset_irn,
  input  logic [1:0]        Addr_ib,
  input  logic [DIN_W-1:0]  Data_ib,
  output logic [DOUT_W-1:0] Data_ob
);

  localparam logic [4:0] LAST_RC  = 5'(ROUNDS);
  localparam logic [2:0] PTR_LAST = 3'(BLOCK_W / DOUT_W - 1);

  fsm_e               fsm_q,    fsm_d;
  logic [BLOCK_W-1:0] data_q,   data_d;
  logic [KEY_W-1:0]   key_q,    key_d;
  logic [BLOCK_W-1:0] state_q,  state_d;
  logic [KEY_W-1:0]   rkey_q,   rkey_d;
  logic [4:0]         rc_q,     rc_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic [2:0]         ptr_q,    ptr_d;
  logic               err_q,    err_d;
  logic               done_q,   done_d;
  logic [DOUT_W-1:0]  dout_q,   dout_d;

  logic               busy;
  logic [BLOCK_W-1:0] round_state;
  logic [KEY_W-1:0]   round_rkey;
  logic [BLOCK_W-1:0] rd_shift;

  fosfor_present_round u_round (
    .state_i (state_q),
    .rkey_i  (rkey_q),
    .rc_i    (rc_q),
    .state_o (round_state),
    .rkey_o  (round_rkey)
  );

  assign busy    = (fsm_q == ST_RUN) || (fsm_q == ST_FIN);
  assign Data_ob = dout_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    fsm_d    = fsm_q;
    data_d   = data_q;
    key_d    = key_q;
    state_d  = state_q;
    rkey_d   = rkey_q;
    rc_d     = rc_q;
    result_d = result_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    done_d   = done_q;
    rd_shift = result_q << (int'(ptr_q) * DOUT_W);
    dout_d   = '0;

    case (fsm_q)
      ST_RUN: begin
        state_d = round_state;
        rkey_d  = round_rkey;
        rc_d    = rc_q + 5'd1;
        if (rc_q == LAST_RC) fsm_d = ST_FIN;
      end
      ST_FIN: begin
        result_d = state_q ^ rkey_q[79:16];
        ptr_d    = '0;
        done_d   = 1'b1;
        fsm_d    = ST_DONE;
      end
      default: ;
    endcase

    // Host access; decoded after the FSM so ABORT can override FIN.
    case (Addr_ib)
      ADDR_DATA: begin
        if (busy) err_d = 1'b1;
        else      data_d = {data_q[BLOCK_W-1-DIN_W:0], Data_ib};
      end
      ADDR_KEY: begin
        if (busy) err_d = 1'b1;
        else      key_d = {key_q[KEY_W-1-DIN_W:0], Data_ib};
      end
      ADDR_CMD: begin
        case (Data_ib[3:0])
          CMD_NOP: ;
          CMD_START: begin
            if (busy) begin
              err_d = 1'b1;
            end else begin
              fsm_d   = ST_RUN;
              state_d = data_q;
              rkey_d  = key_q;
              rc_d    = 5'd1;
              done_d  = 1'b0;
            end
          end
          CMD_RD_RST: ptr_d = '0;
          CMD_RD_NEXT: begin
            if (fsm_q != ST_FIN) ptr_d = (ptr_q == PTR_LAST) ? 3'd0 : ptr_q + 3'd1;
          end
          CMD_ABORT: begin
            fsm_d    = ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            ptr_d    = ptr_q;
          end
          CMD_CLR_ERR: begin
            err_d = 1'b0;
            if (fsm_q != ST_FIN) done_d = 1'b0;
          end
          default: err_d = 1'b1;
        endcase
      end
      default: ;
    endcase

    if (Addr_ib[1]) begin
      dout_d = rd_shift[BLOCK_W-1 -: DOUT_W];
    end else begin
      dout_d[STAT_BUSY]            = busy;
      dout_d[STAT_DONE]            = done_q;
      dout_d[STAT_ERR]             = err_q;
      dout_d[STAT_PTR_LSB +: 3]    = ptr_q;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) begin
      // NOTE: data and key are wide but still reset, so no secret survives a reset.
      fsm_q    <= ST_IDLE;
      data_q   <= '0;
      key_q    <= '0;
      state_q  <= '0;
      rkey_q   <= '0;
      rc_q     <= '0;
      result_q <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      fsm_q    <= fsm_d;
      data_q   <= data_d;
      key_q    <= key_d;
      state_q  <= state_d;
      rkey_q   <= rkey_d;
      rc_q     <= rc_d;
      result_q <= result_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: tb/tb_fosfor_present_engine.sv
// Bench for fosfor_present_engine: default build, a 8-in/64-out build and a
// one-round build, checked against a behavioural PRESENT-80 model.
module tb_fosfor_present_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fosfor_present_if #(.DIN_W(4), .DOUT_W(8))  bus_a ();
  fosfor_present_if #(.DIN_W(8), .DOUT_W(64)) bus_b ();
  logic [7:0] dout_r1;

  fosfor_present_engine #(.DIN_W(4), .DOUT_W(8), .ROUNDS(31)) dut (
    .Clk_ik(clk), .Reset_irn(rst_n), .Addr_ib(bus_a.addr), .Data_ib(bus_a.din), .Data_ob(bus_a.dout));
  fosfor_present_engine #(.DIN_W(8), .DOUT_W(64), .ROUNDS(31)) dut_wide (
    .Clk_ik(clk), .Reset_irn(rst_n), .Addr_ib(bus_b.addr), .Data_ib(bus_b.din), .Data_ob(bus_b.dout));
  fosfor_present_engine #(.DIN_W(4), .DOUT_W(8), .ROUNDS(1)) dut_r1 (
    .Clk_ik(clk), .Reset_irn(rst_n), .Addr_ib(bus_a.addr), .Data_ib(bus_a.din), .Data_ob(dout_r1));

  // Shadow of the default DUT's data/key shift registers.
  logic [63:0] data_m;
  logic [79:0] key_m;

  // ---------------- reference model ----------------
  localparam logic [63:0] SB_ROW = 64'hC56B90AD3EF84712;

  function automatic logic [3:0] sb(input logic [3:0] n);
    logic [63:0] row;
    row = SB_ROW;
    return row[63 - 4*int'(n) -: 4];
  endfunction

  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key,
                                              input int rounds);
    logic [63:0] st, t;
    logic [79:0] k;
    st = pt;
    k  = key;
    for (int r = 1; r <= rounds; r++) begin
      st = st ^ k[79:16];
      t  = '0;
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sb(st[4*n +: 4]);
      st = '0;
      for (int i = 0; i < 63; i++) st[(16*i) % 63] = t[i];
      st[63]    = t[63];
      k         = {k[18:0], k[79:19]};
      k[79:76]  = sb(k[79:76]);
      k[19:15]  = k[19:15] ^ 5'(r);
    end
    return st ^ k[79:16];
  endfunction

  // ---------------- bus helpers ----------------
  task automatic do_reset();
    bus_a.addr = 2'b00; bus_a.din = '0;
    bus_b.addr = 2'b00; bus_b.din = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    data_m = '0;
    key_m  = '0;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [3:0] d);
    bus_a.addr = a; bus_a.din = d;
    @(posedge clk); #1;
    bus_a.addr = 2'b00; bus_a.din = '0;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [7:0] d);
    bus_b.addr = a; bus_b.din = d;
    @(posedge clk); #1;
    bus_b.addr = 2'b00; bus_b.din = '0;
  endtask

  task automatic load_a(input logic [63:0] pt, input logic [79:0] key);
    for (int i = 15; i >= 0; i--) wr_a(2'b10, pt[4*i +: 4]);
    for (int i = 19; i >= 0; i--) wr_a(2'b11, key[4*i +: 4]);
    data_m = pt;
    key_m  = key;
  endtask

  task automatic load_b(input logic [63:0] pt, input logic [79:0] key);
    for (int i = 7; i >= 0; i--) wr_b(2'b10, pt[8*i +: 8]);
    for (int i = 9; i >= 0; i--) wr_b(2'b11, key[8*i +: 8]);
  endtask

  task automatic idle_a(output logic [7:0] st);
    @(posedge clk); #1;
    st = bus_a.dout;
  endtask

  // which: 0 default DUT, 1 one-round DUT, 2 wide DUT. k = clocks until done shows.
  task automatic wait_done(input int which, output int k);
    logic [63:0] ob;
    int c;
    k = -1;
    c = 0;
    while (k < 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
      ob = (which == 0) ? 64'(bus_a.dout) : (which == 1) ? 64'(dout_r1) : bus_b.dout;
      if (ob[1]) k = c;
    end
    if (k < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: dut %0d gave no done within %0d clocks", which, c);
    end
  endtask

  // Reads all 8 byte chunks through Addr 10 (shifting zeros into the data register).
  task automatic read_res(input int which, output logic [63:0] r);
    r = '0;
    wr_a(2'b01, 4'd2);
    for (int i = 0; i < 8; i++) begin
      wr_a(2'b10, 4'h0);
      r = {r[55:0], (which == 0) ? bus_a.dout : dout_r1};
      wr_a(2'b01, 4'd3);
    end
    if (which == 0) data_m = data_m << 32;
  endtask

  task automatic run_a(output int k, output logic [63:0] r);
    wr_a(2'b01, 4'd1);
    wait_done(0, k);
    read_res(0, r);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] st;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.dout !== 8'h00 || bus_b.dout !== 64'h0 || dout_r1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_in: got %h/%h/%h want 0", bus_a.dout, bus_b.dout, dout_r1);
    end
    do_reset();
    idle_a(st);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", st); end
  endtask

  task automatic test_zero_vector();
    logic [63:0] r, want;
    logic [7:0]  st;
    int bad;
    want = 64'h5579C1387B228445;
    load_a(64'h0, 80'h0);
    wr_a(2'b01, 4'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      idle_a(st);
      if (st !== 8'h01) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_window: %0d of 32 clocks not 01, want 0", bad); end
    idle_a(st);
    checks++;
    if (st !== 8'h02) begin errors++; $display("FAIL done_status: got %h want 02", st); end
    read_res(0, r);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[63-8*i -: 8] !== want[63-8*i -: 8]) begin
        errors++;
        $display("FAIL zero_chunk%0d: got %h want %h", i, r[63-8*i -: 8], want[63-8*i -: 8]);
      end
    end
  endtask

  task automatic test_known_vectors();
    logic [63:0] pts  [3] = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    logic [79:0] keys [3] = '{80'hFFFFFFFFFFFFFFFFFFFF, 80'h0, 80'hFFFFFFFFFFFFFFFFFFFF};
    logic [63:0] exps [3] = '{64'hE72C46C0F5945049, 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    logic [63:0] r;
    int k;
    for (int v = 0; v < 3; v++) begin
      load_a(pts[v], keys[v]);
      run_a(k, r);
      checks++;
      if (k != 33) begin errors++; $display("FAIL latency_v%0d: got %0d want 33", v, k); end
      checks++;
      if (r !== exps[v]) begin errors++; $display("FAIL known_v%0d: got %h want %h", v, r, exps[v]); end
    end
  endtask

  task automatic test_random();
    logic [63:0] pt, r, want;
    logic [79:0] key;
    int k;
    for (int v = 0; v < 4; v++) begin
      pt  = {$urandom(), $urandom()};
      key = {16'($urandom()), $urandom(), $urandom()};
      load_a(pt, key);
      want = present_enc(pt, key, 31);
      run_a(k, r);
      checks++;
      if (r !== want) begin errors++; $display("FAIL random_v%0d: got %h want %h", v, r, want); end
    end
  endtask

  task automatic test_errors();
    logic [63:0] r;
    logic [7:0]  st;
    int k;
    load_a(64'h0, 80'h0);
    wr_a(2'b01, 4'd1);
    repeat (2) idle_a(st);
    wr_a(2'b01, 4'd1);
    wr_a(2'b10, 4'h5);
    wait_done(0, k);
    idle_a(st);
    checks++;
    if (st !== 8'h06) begin errors++; $display("FAIL err_status: got %h want 06", st); end
    read_res(0, r);
    checks++;
    if (r !== 64'h5579C1387B228445) begin errors++; $display("FAIL err_result: got %h want 5579C1387B228445", r); end
    run_a(k, r);
    checks++;
    if (r !== 64'h5579C1387B228445) begin errors++; $display("FAIL busy_shift_ignored: got %h want 5579C1387B228445", r); end
    wr_a(2'b01, 4'd5);
    idle_a(st);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL clr_err: got %h want 00", st); end
    wr_a(2'b01, 4'hA);
    idle_a(st);
    checks++;
    if (st !== 8'h04) begin errors++; $display("FAIL illegal_cmd: got %h want 04", st); end
    wr_a(2'b01, 4'd5);
    idle_a(st);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL clr_err2: got %h want 00", st); end
  endtask

  task automatic test_abort();
    logic [63:0] pt, r, prev, want;
    logic [79:0] key;
    logic [7:0]  st;
    int k;
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    load_a(pt, key);
    prev = present_enc(pt, key, 31);
    run_a(k, r);
    checks++;
    if (r !== prev) begin errors++; $display("FAIL abort_setup: got %h want %h", r, prev); end
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    load_a(pt, key);
    wr_a(2'b01, 4'd1);
    repeat (10) idle_a(st);
    wr_a(2'b01, 4'd4);
    idle_a(st);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL abort_status: got %h want 00", st); end
    read_res(0, r);
    checks++;
    if (r !== prev) begin errors++; $display("FAIL abort_result: got %h want %h", r, prev); end
    want = present_enc(data_m, key_m, 31);
    run_a(k, r);
    checks++;
    if (r !== want) begin errors++; $display("FAIL after_abort: got %h want %h", r, want); end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] r;
    logic [7:0]  st;
    load_a({$urandom(), $urandom()}, {16'($urandom()), $urandom(), $urandom()});
    wr_a(2'b01, 4'd1);
    repeat (5) idle_a(st);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.dout !== 8'h00) begin errors++; $display("FAIL midrun_async: got %h want 00", bus_a.dout); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_m = '0;
    key_m  = '0;
    idle_a(st);
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL midrun_status: got %h want 00", st); end
    read_res(0, r);
    checks++;
    if (r !== 64'h0) begin errors++; $display("FAIL midrun_result: got %h want 0", r); end
  endtask

  task automatic test_wide();
    logic [63:0] pt, want;
    logic [79:0] key;
    int k;
    do_reset();
    load_b(64'h0, 80'h0);
    wr_b(2'b01, 8'h01);
    wait_done(2, k);
    checks++;
    if (k != 33) begin errors++; $display("FAIL wide_latency: got %0d want 33", k); end
    wr_b(2'b10, 8'h00);
    checks++;
    if (bus_b.dout !== 64'h5579C1387B228445) begin
      errors++; $display("FAIL wide_zero: got %h want 5579C1387B228445", bus_b.dout);
    end
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    want = present_enc(pt, key, 31);
    load_b(pt, key);
    wr_b(2'b01, 8'hF1);
    wait_done(2, k);
    wr_b(2'b10, 8'h00);
    checks++;
    if (bus_b.dout !== want) begin errors++; $display("FAIL wide_random: got %h want %h", bus_b.dout, want); end
  endtask

  task automatic test_rounds1();
    logic [63:0] pt, r, want;
    logic [79:0] key;
    logic [7:0]  exp_st [3] = '{8'h01, 8'h01, 8'h02};
    logic [7:0]  st;
    do_reset();
    pt  = {$urandom(), $urandom()};
    key = {16'($urandom()), $urandom(), $urandom()};
    want = present_enc(pt, key, 1);
    load_a(pt, key);
    wr_a(2'b01, 4'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      st = dout_r1;
      checks++;
      if (st !== exp_st[k]) begin errors++; $display("FAIL r1_status%0d: got %h want %h", k + 1, st, exp_st[k]); end
    end
    read_res(1, r);
    checks++;
    if (r !== want) begin errors++; $display("FAIL r1_result: got %h want %h", r, want); end
  endtask

  initial begin
    bus_a.addr = 2'b00; bus_a.din = '0;
    bus_b.addr = 2'b00; bus_b.din = '0;
    data_m = '0;
    key_m  = '0;
    test_reset();
    test_zero_vector();
    test_known_vectors();
    test_random();
    test_errors();
    test_abort();
    test_reset_midrun();
    test_wide();
    test_rounds1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
